// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, default latencies and the 32-bit division helpers for the HI/LO unit.
// The decoder drives op using these same constants.
package mult_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Returns {remainder, quotient}. A zero divisor yields zeros; the caller never commits them.
  function automatic logic [63:0] mdu_divu(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q;
    logic [31:0] r;
    if (d == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  // Signed division on magnitudes: quotient truncates toward zero, remainder follows
  // the dividend's sign. 0x80000000 / -1 wraps to 0x80000000 with a zero remainder.
  function automatic logic [63:0] mdu_div(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] n_mag;
    logic [31:0] d_mag;
    logic [63:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    n_mag = n[31] ? (~n + 32'd1) : n;
    d_mag = d[31] ? (~d + 32'd1) : d;
    ur    = mdu_divu(n_mag, d_mag);
    q     = (n[31] ^ d[31]) ? (~ur[31:0] + 32'd1) : ur[31:0];
    r     = n[31] ? (~ur[63:32] + 32'd1) : ur[63:32];
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage HI/LO multiply/divide unit: result computed at issue, held in pend_hi/pend_lo,
// and committed after a fixed countdown so the hazard unit sees the architected latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_ok;

  logic [63:0] res;
  logic        is_mul;
  logic        is_div;

  always_comb begin
    res    = 64'd0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (op)
      MDU_MULT: begin
        res    = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        is_mul = 1'b1;
      end
      MDU_MULTU: begin
        res    = {32'd0, a} * {32'd0, b};
        is_mul = 1'b1;
      end
      MDU_DIV: begin
        res    = mdu_div(a, b);
        is_div = 1'b1;
      end
      MDU_DIVU: begin
        res    = mdu_divu(a, b);
        is_div = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      count   <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end else if (is_mul || is_div) begin
              pend_hi <= res[63:32];
              pend_lo <= res[31:0];
              pend_ok <= !(is_div && (b == 32'd0));
              count   <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              busy    <= 1'b1;
              state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // start/op are ignored here; the hazard unit keeps them quiet anyway
          if (count == CNT_W'(1)) begin
            if (pend_ok) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            count <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of issue/result records plus
// hand-written sequences for busy-time start, mid-op reset and back-to-back issue.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // All drives happen #1 after a rising edge, so samples taken there see settled outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = 3'd7;
    a     = 32'd0;
    b     = 32'd0;
  endtask

  // Counts cycles from the issue edge until busy drops; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;

    vecs[0]  = '{"mthi",        3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
    vecs[1]  = '{"mult_neg",    3'd0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[2]  = '{"multu",       3'd1, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[3]  = '{"div_neg",     3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{"divu",        3'd3, 32'h7,        32'h2,        32'h00000001, 32'h00000003, 10};
    vecs[5]  = '{"mthi_a",      3'd4, 32'hA,        32'h0,        32'h0000000A, 32'h00000003, 0};
    vecs[6]  = '{"mtlo_b",      3'd5, 32'hB,        32'h0,        32'h0000000A, 32'h0000000B, 0};
    vecs[7]  = '{"div_by_zero", 3'd2, 32'h5,        32'h0,        32'h0000000A, 32'h0000000B, 10};
    vecs[8]  = '{"div_ovf",     3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[9]  = '{"reserved",    3'd6, 32'hDEAD,     32'h1,        32'h00000000, 32'h80000000, 0};
    vecs[10] = '{"div_negdiv",  3'd2, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[11] = '{"mult_negneg", 3'd0, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 5};
    vecs[12] = '{"divu_big",    3'd3, 32'hFFFFFFFF, 32'hA,        32'h00000005, 32'h19999999, 10};

    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // table-driven vectors
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      check({vecs[i].name, "_cycles"}, 64'(n), 64'(vecs[i].exp_cyc));
      check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
    end

    // start during busy is ignored; hi/lo hold old values while busy
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue(3'd0, 32'd3, 32'd4);
    start = 1'b1;
    op    = 3'd5;
    a     = 32'h55;
    tick();
    start = 1'b0;
    op    = 3'd7;
    a     = 32'd0;
    check("busy_hold_busy", 64'(busy), 64'd1);
    check("busy_hold_hilo", {hi, lo}, 64'd0);
    wait_idle(n);
    check("busy_ign_cycles", 64'(n + 1), 64'd5);
    check("busy_ign_hilo", {hi, lo}, {32'd0, 32'd12});

    // reset in the third busy cycle of a DIVU discards everything
    issue(3'd4, 32'h77, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    check("midop_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midop_busy", 64'(busy), 64'd0);
    check("midop_hilo", {hi, lo}, 64'd0);

    // back-to-back: new op issued the cycle busy falls
    issue(3'd3, 32'd9, 32'd2);
    wait_idle(n);
    check("b2b_first_hilo", {hi, lo}, {32'd1, 32'd4});
    issue(3'd1, 32'd2, 32'd3);
    check("b2b_accept_busy", 64'(busy), 64'd1);
    wait_idle(n);
    check("b2b_cycles", 64'(n), 64'd5);
    check("b2b_hilo", {hi, lo}, {32'd0, 32'd6});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time guard
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
